// File: rtl/vga_pkg.sv
// vga_pkg: timing constants and receiver state encoding shared by the vga transmitter and vga_rx
//   H_* / V_* : 640x480@60 horizontal (pixel clocks) and vertical (lines) timing
//   *_ACT_*   : active-window bounds in sync-relative counter coordinates
//   rx_state_t: lock state of the receiver
package vga_pkg;
    localparam int H_SYNC      = 96;
    localparam int H_BP        = 48;
    localparam int H_ACTIVE    = 640;
    localparam int H_TOTAL     = 800;
    localparam int V_SYNC      = 2;
    localparam int V_BP        = 33;
    localparam int V_ACTIVE    = 480;
    localparam int V_TOTAL     = 525;
    localparam int H_ACT_START = H_SYNC + H_BP;
    localparam int H_ACT_END   = H_ACT_START + H_ACTIVE;
    localparam int V_ACT_START = V_SYNC + V_BP;
    localparam int V_ACT_END   = V_ACT_START + V_ACTIVE;
    typedef enum logic [1:0] {RX_UNLOCKED, RX_SYNCING, RX_LOCKED} rx_state_t;
endpackage

// File: rtl/vga_rx_if.sv
// vga_rx_if: video stream under test into vga_rx and the recovered pixel stream out of it
//   i_vga_hs/vs, i_vga_r/g/b : sampled sync and colour (master drives)
//   o_x/o_y/o_de, o_r/g/b    : recovered coordinates, active flag, aligned colour (slave drives)
interface vga_rx_if;
    logic       i_vga_hs;
    logic       i_vga_vs;
    logic [3:0] i_vga_r;
    logic [3:0] i_vga_g;
    logic [3:0] i_vga_b;
    logic [9:0] o_x;
    logic [9:0] o_y;
    logic       o_de;
    logic [3:0] o_r;
    logic [3:0] o_g;
    logic [3:0] o_b;
    modport master (output i_vga_hs, i_vga_vs, i_vga_r, i_vga_g, i_vga_b,
                    input  o_x, o_y, o_de, o_r, o_g, o_b);
    modport slave  (input  i_vga_hs, i_vga_vs, i_vga_r, i_vga_g, i_vga_b,
                    output o_x, o_y, o_de, o_r, o_g, o_b);
endinterface

// File: rtl/vga_sync_edge.sv
// vga_sync_edge: registers one sync input and flags the cycle it reaches its asserted level
//   clk_vga, rst_vga : pixel clock, synchronous active-high reset
//   i_sync           : raw sync from the pins
//   o_start          : registered sync is asserted and was deasserted the cycle before
module vga_sync_edge #(
    parameter bit SYNC_POL = 1'b0
) (
    input  logic clk_vga,
    input  logic rst_vga,
    input  logic i_sync,
    output logic o_start
);
    logic sync_q, sync_d, prev_q, prev_d;
    always_comb begin
        sync_d = i_sync;
        prev_d = sync_q;
    end
    // History resets to the asserted level so a sync already active at reset release
    // is not mistaken for a fresh edge.
    always_ff @(posedge clk_vga) begin
        if (rst_vga) begin
            sync_q <= SYNC_POL;
            prev_q <= SYNC_POL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end
    assign o_start = (sync_q == SYNC_POL) && (prev_q != SYNC_POL);
endmodule

// File: rtl/vga_rx.sv
// vga_rx: recovers sync timing and pixel coordinates from a VGA stream, locks, checks and checksums frames
//   clk_vga, rst_vga        : pixel clock, synchronous active-high reset
//   vif (slave)             : sync/colour in; x/y/de and aligned colour out (2-cycle latency)
//   o_locked                : timing lock
//   o_frame_done            : one-cycle pulse when o_frame_sum/o_frame_cnt update
//   o_frame_sum/o_frame_cnt : checksum of last good locked frame, count of such frames
//   o_err_h/o_err_v         : sticky line-length / frame-length errors
module vga_rx #(
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_TOTAL  = vga_pkg::H_TOTAL,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_TOTAL  = vga_pkg::V_TOTAL,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic        clk_vga,
    input  logic        rst_vga,
    vga_rx_if.slave     vif,
    output logic        o_locked,
    output logic        o_frame_done,
    output logic [15:0] o_frame_sum,
    output logic [15:0] o_frame_cnt,
    output logic        o_err_h,
    output logic        o_err_v
);
    import vga_pkg::*;
    localparam int HA0 = H_SYNC + H_BP;
    localparam int HA1 = HA0 + H_ACTIVE;
    localparam int VA0 = V_SYNC + V_BP;
    localparam int VA1 = VA0 + V_ACTIVE;
    rx_state_t   state_q, state_d;
    logic        hs_start, vs_start, line_err, frame_err, active;
    logic [9:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d, x_q, x_d, y_q, y_d;
    logic [11:0] pix_q, pix_d, rgb_q, rgb_d;
    logic        de_q, de_d, h_seen_q, h_seen_d, vs_pend_q, vs_pend_d;
    logic        err_h_q, err_h_d, err_v_q, err_v_d, done_q, done_d;
    logic [15:0] sum_q, sum_d, fsum_q, fsum_d, fcnt_q, fcnt_d, sum_in;
    vga_sync_edge #(.SYNC_POL(SYNC_POL)) u_hs (
        .clk_vga(clk_vga), .rst_vga(rst_vga), .i_sync(vif.i_vga_hs), .o_start(hs_start)
    );
    vga_sync_edge #(.SYNC_POL(SYNC_POL)) u_vs (
        .clk_vga(clk_vga), .rst_vga(rst_vga), .i_sync(vif.i_vga_vs), .o_start(vs_start)
    );
    // h_cnt_d / v_cnt_d are the coordinates of the pixel currently in the input register;
    // the _q copies belong to the previous pixel and give the finished line/frame lengths.
    always_comb begin
        pix_d     = {vif.i_vga_r, vif.i_vga_g, vif.i_vga_b};
        rgb_d     = pix_q;
        h_cnt_d   = hs_start ? 10'd0 : (&h_cnt_q ? h_cnt_q : h_cnt_q + 10'd1);
        v_cnt_d   = !hs_start ? v_cnt_q :
                    (vs_start || vs_pend_q) ? 10'd0 : (&v_cnt_q ? v_cnt_q : v_cnt_q + 10'd1);
        vs_pend_d = hs_start ? 1'b0 : (vs_pend_q || vs_start);
        h_seen_d  = h_seen_q || hs_start;
        line_err  = hs_start && h_seen_q && (({1'b0, h_cnt_q} + 11'd1) != 11'(H_TOTAL));
        frame_err = vs_start && (state_q != RX_UNLOCKED) && (({1'b0, v_cnt_q} + 11'd1) != 11'(V_TOTAL));
        active    = (h_cnt_d >= 10'(HA0)) && (h_cnt_d < 10'(HA1)) &&
                    (v_cnt_d >= 10'(VA0)) && (v_cnt_d < 10'(VA1));
        sum_in    = sum_q + (active ? {4'h0, pix_q} : 16'h0);
        sum_d     = vs_start ? 16'h0 : sum_in;
        err_h_d   = err_h_q || line_err;
        err_v_d   = err_v_q || frame_err;
        state_d   = state_q;
        done_d    = 1'b0;
        fsum_d    = fsum_q;
        fcnt_d    = fcnt_q;
        case (state_q)
            RX_UNLOCKED: state_d = vs_start ? RX_SYNCING : RX_UNLOCKED;
            RX_SYNCING:  state_d = (line_err || frame_err) ? RX_UNLOCKED : (vs_start ? RX_LOCKED : RX_SYNCING);
            RX_LOCKED: begin
                if (line_err || frame_err) begin
                    state_d = RX_UNLOCKED;
                end else if (vs_start) begin
                    done_d = 1'b1;
                    fsum_d = sum_in;
                    fcnt_d = fcnt_q + 16'd1;
                end
            end
            default:     state_d = RX_UNLOCKED;
        endcase
        de_d = (state_d == RX_LOCKED) && active;
        x_d  = de_d ? h_cnt_d - 10'(HA0) : x_q;
        y_d  = de_d ? v_cnt_d - 10'(VA0) : y_q;
    end
    always_ff @(posedge clk_vga) begin
        if (rst_vga) begin
            state_q   <= RX_UNLOCKED;
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            x_q       <= '0;
            y_q       <= '0;
            pix_q     <= '0;
            rgb_q     <= '0;
            de_q      <= 1'b0;
            h_seen_q  <= 1'b0;
            vs_pend_q <= 1'b0;
            err_h_q   <= 1'b0;
            err_v_q   <= 1'b0;
            done_q    <= 1'b0;
            sum_q     <= '0;
            fsum_q    <= '0;
            fcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            x_q       <= x_d;
            y_q       <= y_d;
            pix_q     <= pix_d;
            rgb_q     <= rgb_d;
            de_q      <= de_d;
            h_seen_q  <= h_seen_d;
            vs_pend_q <= vs_pend_d;
            err_h_q   <= err_h_d;
            err_v_q   <= err_v_d;
            done_q    <= done_d;
            sum_q     <= sum_d;
            fsum_q    <= fsum_d;
            fcnt_q    <= fcnt_d;
        end
    end
    assign vif.o_x      = x_q;
    assign vif.o_y      = y_q;
    assign vif.o_de     = de_q;
    assign vif.o_r      = rgb_q[11:8];
    assign vif.o_g      = rgb_q[7:4];
    assign vif.o_b      = rgb_q[3:0];
    assign o_locked     = state_q == RX_LOCKED;
    assign o_frame_done = done_q;
    assign o_frame_sum  = fsum_q;
    assign o_frame_cnt  = fcnt_q;
    assign o_err_h      = err_h_q;
    assign o_err_v      = err_v_q;
endmodule
